// File: rtl/pc_pkg.sv
// Shared constants for the serial program-counter sequencer: instruction stride
// and the RUN/HOLD state encoding.
package pc_pkg;
  localparam int unsigned PC_STRIDE = 4;

  typedef logic [0:0] pc_state_t;
  localparam pc_state_t ST_RUN  = 1'b0;
  localparam pc_state_t ST_HOLD = 1'b1;
endpackage

// File: rtl/pc_seq_if.sv
// Control/status bundle between the instruction sequencer (slave) and whatever
// drives redirects and stalls (master).
interface pc_seq_if #(
  parameter int XLEN = 32,
  parameter int PW   = 7
);
  logic            stall;
  logic            enl;
  logic [XLEN-1:0] load;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] count;
  logic [PW-1:0]   phase;
  logic            instr_done;
  logic            misalign;
  logic            ras_ovf;
  logic            ras_unf;

  modport master (
    output stall, enl, load, call, ret,
    input  count, phase, instr_done, misalign, ras_ovf, ras_unf
  );

  modport slave (
    input  stall, enl, load, call, ret,
    output count, phase, instr_done, misalign, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push on full overwrites the oldest entry,
// push together with pop replaces the top entry in place.
module pc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            full,
  output logic            empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   ptr;
  logic [AW:0]     occ;
  logic            pop_eff;

  assign empty   = (occ == '0);
  assign full    = (occ == (AW+1)'(DEPTH));
  assign top     = mem[ptr - AW'(1)];
  assign pop_eff = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      occ <= '0;
    end else if (push && !pop_eff) begin
      ptr <= ptr + AW'(1);
      if (!full) occ <= occ + (AW+1)'(1);
    end else if (pop_eff && !push) begin
      ptr <= ptr - AW'(1);
      occ <= occ - (AW+1)'(1);
    end
  end

  // Pointer wraps mod DEPTH, so a push on full lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (push) mem[pop_eff ? ptr - AW'(1) : ptr] <= din;
  end
endmodule

// File: rtl/pc_seq.sv
// Multi-cycle program counter: commits once per CPI non-stalled cycles with
// redirect > return > sequential priority. Define PC_RAS_EN to add the return stack.
module pc_seq
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              CPI       = 99,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input logic         clk,
  input logic         reset,
  pc_seq_if.slave     bus
);
  localparam int            PW      = (CPI > 1) ? $clog2(CPI) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CPI - 1);

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  pc_state_t       state;
  logic            run, bnd, redir;
  logic [PW-1:0]   phase_q;
  logic [XLEN-1:0] count_q, pend_tgt, tgt, seq_pc, alt_pc, next_pc;
  logic            pend_q, done_q, mis_q;

  assign state   = bus.stall ? ST_HOLD : ST_RUN;
  assign run     = (state == ST_RUN);
  assign bnd     = run && (phase_q == PH_LAST);
  // A same-cycle enl wins over the pending target (last request wins).
  assign redir   = bus.enl | pend_q;
  assign tgt     = bus.enl ? bus.load : pend_tgt;
  assign seq_pc  = count_q + XLEN'(PC_STRIDE);
  assign next_pc = redir ? align_word(tgt) : alt_pc;

`ifdef PC_RAS_EN
  logic            ras_push, ret_take, ras_full, ras_empty;
  logic [XLEN-1:0] ras_top;
  logic            ovf_q, unf_q;

  assign ras_push = bnd & bus.call;
  assign ret_take = bnd & bus.ret & ~redir;
  assign alt_pc   = (ret_take && !ras_empty) ? ras_top : seq_pc;

  pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ret_take),
    .din   (seq_pc),
    .top   (ras_top),
    .full  (ras_full),
    .empty (ras_empty)
  );

  // call+ret together is a top replacement, so neither flag fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ras_push & ~ret_take & ras_full;
      unf_q <= ret_take & ~bus.call & ras_empty;
    end
  end

  assign bus.ras_ovf = ovf_q;
  assign bus.ras_unf = unf_q;
`else
  logic unused_ras;
  assign unused_ras  = bus.call ^ bus.ret;
  assign alt_pc      = seq_pc;
  assign bus.ras_ovf = 1'b0;
  assign bus.ras_unf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VEC;
      phase_q <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      done_q <= bnd;
      mis_q  <= bnd & redir & (|tgt[1:0]);
      if (run) phase_q <= bnd ? '0 : phase_q + PW'(1);
      if (bnd) begin
        count_q <= next_pc;
        pend_q  <= 1'b0;
      end else if (bus.enl) begin
        pend_q  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.enl && !bnd) pend_tgt <= bus.load;
  end

  assign bus.count      = count_q;
  assign bus.phase      = phase_q;
  assign bus.instr_done = done_q;
  assign bus.misalign   = mis_q;
endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq (CPI=4, RESET_VEC=0x100); the RAS section is
// compiled in when PC_RAS_EN is defined.
module tb_pc_seq;
  localparam int          XLEN      = 32;
  localparam int          CPI       = 4;
  localparam int          PW        = 2;
  localparam int          RAS_DEPTH = 4;
  localparam logic [31:0] RV        = 32'h100;

  logic clk = 1'b0;
  logic reset;

  pc_seq_if #(.XLEN(XLEN), .PW(PW)) bus ();

  pc_seq #(.XLEN(XLEN), .CPI(CPI), .RESET_VEC(RV), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          mis;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  // Reference state: PC, position inside the instruction, pending redirect, stack
  logic [31:0] m_count;
  int          m_ph;
  bit          m_pend;
  logic [31:0] m_tgt;
  logic [31:0] m_stack[$];

  function void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function void model_predict();
    exp_t        e;
    bit          redir;
    logic [31:0] t;
    logic [31:0] seq;
    if (reset) begin
      m_count = RV;
      m_ph    = 0;
      m_pend  = 0;
      m_stack.delete();
    end else if (bus.stall) begin
      if (bus.enl) begin m_pend = 1; m_tgt = bus.load; end
    end else if (m_ph == CPI - 1) begin
      redir = bus.enl || m_pend;
      t     = bus.enl ? bus.load : m_tgt;
      seq   = m_count + 32'd4;
      e.pc  = seq;
      e.mis = 0;
      e.ovf = 0;
      e.unf = 0;
      if (redir) begin
        e.pc  = t & ~32'd3;
        e.mis = (t % 4) != 0;
      end
`ifdef PC_RAS_EN
      if (bus.ret && !redir) begin
        if (m_stack.size() > 0) e.pc = m_stack.pop_back();
        else if (!bus.call) e.unf = 1;
      end
      if (bus.call) begin
        if (m_stack.size() == RAS_DEPTH) begin
          void'(m_stack.pop_front());
          e.ovf = 1;
        end
        m_stack.push_back(seq);
      end
`endif
      sbq.push_back(e);
      m_count = e.pc;
      m_ph    = 0;
      m_pend  = 0;
    end else begin
      m_ph++;
      if (bus.enl) begin m_pend = 1; m_tgt = bus.load; end
    end
  endfunction

  task automatic step(input bit r, input bit st, input bit en, input logic [31:0] ld,
                      input bit cl, input bit rt);
    @(negedge clk);
    reset     = r;
    bus.stall = st;
    bus.enl   = en;
    bus.load  = ld;
    bus.call  = cl;
    bus.ret   = rt;
    model_predict();
    @(posedge clk);
    #1;
    chk("count", bus.count, m_count);
    chk("phase", bus.phase, m_ph);
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic to_phase(input int p);
    for (int i = 0; i < 2 * CPI && m_ph != p; i++) idle();
  endtask

  task automatic run_done(input bit cl, input bit rt, output int n);
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      step(0, 0, 0, 32'h0, cl, rt);
      if (bus.instr_done === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL run_done: no instr_done within 64 cycles");
    end
  endtask

  // Monitor: every instr_done pops one expected commit.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.instr_done === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got instr_done=1 required 0");
        end else begin
          e = sbq.pop_front();
          chk("commit_pc", bus.count, e.pc);
          chk("commit_misalign", bus.misalign, e.mis);
          chk("commit_ras_ovf", bus.ras_ovf, e.ovf);
          chk("commit_ras_unf", bus.ras_unf, e.unf);
        end
      end else begin
        chk("idle_pulses", {bus.instr_done, bus.misalign, bus.ras_ovf, bus.ras_unf}, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = 1'b1;
    bus.stall = 1'b0;
    bus.enl   = 1'b0;
    bus.load  = '0;
    bus.call  = 1'b0;
    bus.ret   = 1'b0;

    step(1, 0, 0, 32'h0, 0, 0);
    step(1, 0, 0, 32'h0, 0, 0);
    mon_en = 1'b1;
    chk("rst_count", bus.count, 32'h100);
    chk("rst_phase", bus.phase, 0);
    chk("rst_pulses", {bus.instr_done, bus.misalign, bus.ras_ovf, bus.ras_unf}, 0);
    // Reset wins over every other input in the same cycle
    step(1, 1, 1, 32'h999, 1, 1);
    chk("rst_override_count", bus.count, 32'h100);

    run_done(0, 0, n);
    chk("first_instr_cycles", n, CPI);
    chk("first_commit", bus.count, 32'h104);
    run_done(0, 0, n);
    chk("second_instr_cycles", n, CPI);
    chk("second_commit", bus.count, 32'h108);

    to_phase(1);
    step(0, 0, 1, 32'h200, 0, 0);
    chk("redir_hold", bus.count, 32'h108);
    run_done(0, 0, n);
    chk("redir_commit", bus.count, 32'h200);
    run_done(0, 0, n);
    chk("pending_cleared", bus.count, 32'h204);

    to_phase(0);
    step(0, 0, 1, 32'h300, 0, 0);
    to_phase(2);
    step(0, 0, 1, 32'h400, 0, 0);
    run_done(0, 0, n);
    chk("last_wins", bus.count, 32'h400);
    step(0, 0, 1, 32'h203, 0, 0);
    run_done(0, 0, n);
    chk("misalign_pc", bus.count, 32'h200);
    chk("misalign_pulse", bus.misalign, 1);

    to_phase(CPI - 1);
    step(0, 0, 1, 32'h700, 0, 0);
    chk("same_cycle_done", bus.instr_done, 1);
    chk("same_cycle_pc", bus.count, 32'h700);

    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    run_done(0, 0, n);
    chk("top_pc", bus.count, 32'hFFFF_FFFC);
    run_done(0, 0, n);
    chk("wrap_pc", bus.count, 32'h0);

    to_phase(2);
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 1, 1, 32'h500, 0, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    step(0, 1, 0, 32'h0, 0, 0);
    chk("stall_phase", bus.phase, 2);
    run_done(0, 0, n);
    chk("stall_remaining", n, CPI - 2);
    chk("stall_enl_commit", bus.count, 32'h500);

    to_phase(1);
    step(0, 0, 1, 32'h600, 0, 0);
    step(1, 0, 0, 32'h0, 0, 0);
    run_done(0, 0, n);
    chk("rst_discard_cycles", n, CPI);
    chk("rst_discard_pc", bus.count, 32'h104);

`ifdef PC_RAS_EN
    step(1, 0, 0, 32'h0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      run_done(1, 0, n);
      chk("ras_ovf_seq", bus.ras_ovf, (k == 5));
    end
    step(1, 0, 0, 32'h0, 0, 0);
    run_done(0, 1, n);
    chk("ras_unf_pc", bus.count, 32'h104);
    chk("ras_unf_pulse", bus.ras_unf, 1);
    step(1, 0, 0, 32'h0, 0, 0);
    to_phase(CPI - 1);
    step(0, 0, 1, 32'h800, 1, 0);
    chk("call_target", bus.count, 32'h800);
    run_done(0, 1, n);
    chk("ret_target", bus.count, 32'h104);
`endif

    step(1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 6) == 0), $urandom,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end
    idle();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter XLEN, default 32, program counter width in bits.
REQ-002 Parameter CPI, default 99, clock cycles per serial instruction (minimum 2).
REQ-003 Parameter RESET_VEC, default 0, PC value after reset (word-aligned).
REQ-004 Parameter RAS_DEPTH, default 4, return-address stack entries (power of two, used only with PC_RAS_EN).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 stall  input  1  freezes phase counter and PC while high.
REQ-008 enl  input  1  redirect request (branch/jump).
REQ-009 load  input  XLEN  redirect target, sampled when enl=1.
REQ-010 call  input  1  push return address at the current instruction boundary (PC_RAS_EN only).
REQ-011 ret  input  1  pop return target at the current instruction boundary (PC_RAS_EN only).
REQ-012 count  output  XLEN  current program counter.
REQ-013 phase  output  clog2(CPI)  cycle index within the current instruction, 0..CPI-1.
REQ-014 instr_done  output  1  one-cycle pulse in the cycle the PC commits.
REQ-015 misalign  output  1  one-cycle pulse when a committed target had load[1:0]!=0.
REQ-016 ras_ovf, ras_unf  output  1 each  one-cycle stack overflow/underflow pulses (tied 0 without PC_RAS_EN).

Function
REQ-017 phase shall increment by 1 per non-stalled cycle and wrap from CPI-1 to 0.
REQ-018 The boundary cycle is phase==CPI-1 with stall=0; the PC shall commit only there, so count is constant for exactly CPI non-stalled cycles.
REQ-019 instr_done shall be registered and high for exactly one cycle, the cycle after the boundary edge.
REQ-020 An enl pulse in any phase shall latch load into a pending-target register and set a pending flag; a later enl before the boundary shall overwrite it (last wins).
REQ-021 enl asserted on the boundary cycle itself shall be used directly for that commit.
REQ-022 Next PC priority at commit: redirect (pending or same-cycle) > ret > count+4.
REQ-023 count+4 shall wrap modulo 2^XLEN (all-ones-minus-3 + 4 -> 0) with no flag.
REQ-024 A redirect target with bits[1:0]!=0 shall commit with bits[1:0] cleared and pulse misalign.
REQ-025 The pending flag shall clear at the commit that consumes it.
REQ-026 stall high shall hold phase, count and the pending state; enl during stall shall still be captured.
REQ-027 The block is a two-state machine: RUN (phase advancing) and HOLD (stall=1); HOLD->RUN resumes at the held phase.

Reset
REQ-028 On reset=1 at a clock edge: count=RESET_VEC, phase=0, pending cleared, all pulse outputs 0, RAS pointer and occupancy 0; reset overrides stall, enl, call, ret in the same cycle.
REQ-029 Reset mid-instruction shall discard any pending redirect; the next commit occurs CPI cycles after reset deasserts.

Configuration
REQ-030 Macro PC_RAS_EN, when defined, shall compile in the return-address stack: on commit with call=1 push count+4; on commit with ret=1 and no redirect, next PC = top entry and pop.
REQ-031 Push when full shall overwrite the oldest entry (circular) and pulse ras_ovf; ret when empty shall fall back to count+4 and pulse ras_unf.
REQ-032 call and ret together at a commit: pop-then-push (top replaced), no flags.
REQ-033 Without PC_RAS_EN, call and ret shall be ignored, no stack storage is synthesised, ras_ovf/ras_unf are constant 0.

Structure
REQ-034 A shared package pc_pkg shall hold the instruction stride constant (4) and the RUN/HOLD state enumeration.
REQ-035 The stack shall be a separate sub-module pc_ras (push, pop, top, full, empty), instantiated only under PC_RAS_EN.

Verification
REQ-036 CPI=4, RESET_VEC=0x100, release reset -> count=0x100 for 4 cycles, then 0x104, instr_done one pulse per 4 cycles.
REQ-037 enl with load=0x200 at phase 1 -> count unchanged until boundary, then 0x200; pending cleared.
REQ-038 enl load=0x300 at phase 0 then load=0x400 at phase 2 -> commits 0x400; load=0x203 -> commits 0x200 with misalign pulse.
REQ-039 count=0xFFFFFFFC, no redirect -> commits 0x00000000; stall held 5 cycles at phase 2 -> commit delayed exactly 5 cycles.
REQ-040 PC_RAS_EN, RAS_DEPTH=4: 5 calls -> ras_ovf on 5th; ret on empty stack -> count+4 with ras_unf; call at 0x100 then ret -> returns to 0x104.
REQ-041 reset asserted at phase 2 with pending redirect -> count=RESET_VEC, redirect never applied.
